// File: rtl/hash_stream_if.sv
// Block-in / digest-out handshake bundle for hash_stream.
// The master drives blocks and consumes digests; the slave is the hash core.
interface hash_stream_if #(
    parameter int W = 64
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/hash_stream.sv
// Streaming multi-block hash: rotating upper block drives injectors into a ring generator; HASH_BLOCK_CNT_EN adds blk_cnt.
// Latency: ROUNDS cycles per block; digest valid the edge after the last round of the final block.
// Backpressure: in_ready only in IDLE; digest held in OUTPUT until out_ready.
module hash_stream #(
    parameter int             W        = 64,
    parameter int             ROUNDS   = 64,
    parameter logic [W-1:0]   KEY      = W'(5),
    parameter logic [W-1:0]   TAP_MASK = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            normal_mode,
    hash_stream_if.slave    hs,
`ifdef HASH_BLOCK_CNT_EN
    output logic [15:0]     blk_cnt,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ABSORB = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [15:0] LAST_RND = 16'(ROUNDS - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   upper, lower, lower_nx;
    logic [W-1:0]   out_data_q;
    logic           out_valid_q;
    logic           last_q;
    logic           msg_active;
    logic [15:0]    round_cnt;
    logic           blk_acc;
    logic           rnd_done;
    logic           inj0, inj1, inj2, inj3;

    // Ring generator step: shift toward bit 0, feedback from lower[0] through the taps.
    always_comb begin
        inj0 = upper[0];
        inj1 = upper[4] & upper[5];
        inj2 = (upper[9] & upper[10]) | (upper[13] & upper[14]);
        inj3 = upper[16] | (upper[19] & upper[21]);

        lower_nx        = {1'b0, lower[W-1:1]} ^ (TAP_MASK & {W{lower[0]}});
        lower_nx[W-1]   = lower[0] ^ inj0;
        lower_nx[W-9]   = lower_nx[W-9]  ^ inj1;
        lower_nx[W-17]  = lower_nx[W-17] ^ inj2;
        lower_nx[W-25]  = lower_nx[W-25] ^ inj3;
    end

    always_comb begin
        state_d     = state_q;
        blk_acc     = 1'b0;
        rnd_done    = 1'b0;
        hs.in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                hs.in_ready = 1'b1;
                if (hs.in_valid) begin
                    blk_acc = 1'b1;
                    state_d = ABSORB;
                end
            end
            ABSORB: begin
                if (round_cnt == LAST_RND) begin
                    rnd_done = 1'b1;
                    state_d  = last_q ? OUTPUT : IDLE;
                end
            end
            OUTPUT: begin
                if (hs.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            upper       <= '0;
            lower       <= '0;
            last_q      <= 1'b0;
            msg_active  <= 1'b0;
            round_cnt   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (blk_acc) begin
                upper     <= hs.in_data;
                last_q    <= hs.in_last;
                round_cnt <= '0;
                // Chained blocks keep the running lower state; only a new message seeds it.
                if (!msg_active) begin
                    lower      <= normal_mode ? KEY : '0;
                    msg_active <= 1'b1;
                end
            end
            if (state_q == ABSORB) begin
                upper     <= {upper[W-2:0], upper[W-1]};
                lower     <= lower_nx;
                round_cnt <= round_cnt + 16'd1;
                if (rnd_done && last_q) begin
                    out_data_q  <= lower_nx;
                    out_valid_q <= 1'b1;
                    msg_active  <= 1'b0;
                end
            end
            if (state_q == OUTPUT && hs.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef HASH_BLOCK_CNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt_q <= '0;
        end else if (state_q == OUTPUT && hs.out_ready) begin
            blk_cnt_q <= '0;
        end else if (blk_acc && blk_cnt_q != 16'hFFFF) begin
            blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign blk_cnt = blk_cnt_q;
`endif

    assign hs.out_data  = out_data_q;
    assign hs.out_valid = out_valid_q;
    assign busy         = (state_q != IDLE) | msg_active;

endmodule

// File: tb/tb_hash_stream.sv
// Randomized self-checking bench for hash_stream: three parameter sets share one stimulus driver.
module tb_hash_stream;

    localparam logic [2:0][15:0] RNDS = {16'd5, 16'd1, 16'd64};
    localparam logic [2:0][63:0] TAPS = {64'hB3A1_0C5F_9E27_4D11, 64'h0, 64'h0};
    localparam logic [2:0][63:0] KEYS = {64'h0123_4567_89AB_CDEF, 64'd5, 64'd5};
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        nm;
    logic [63:0] din;
    logic        dvld, dlast, ordy;
    logic [1:0]  sel;

    logic [2:0]  ir_w, ov_w, busy_w;
    logic [63:0] od_w [3];
    logic [15:0] blk_w [3];

    logic        ir, ov, bsy;
    logic [63:0] od;
    logic [15:0] bc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hash_stream_if #(.W(64)) hsif ();

        assign hsif.in_data   = din;
        assign hsif.in_last   = dlast;
        assign hsif.in_valid  = dvld && (sel == 2'(g));
        assign hsif.out_ready = ordy && (sel == 2'(g));

        hash_stream #(
            .W        (64),
            .ROUNDS   (int'(RNDS[g])),
            .KEY      (KEYS[g]),
            .TAP_MASK (TAPS[g])
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .normal_mode (nm),
            .hs          (hsif),
`ifdef HASH_BLOCK_CNT_EN
            .blk_cnt     (blk_w[g]),
`endif
            .busy        (busy_w[g])
        );

`ifndef HASH_BLOCK_CNT_EN
        assign blk_w[g] = 16'd0;
`endif
        assign ir_w[g] = hsif.in_ready;
        assign ov_w[g] = hsif.out_valid;
        assign od_w[g] = hsif.out_data;
    end

    assign ir  = ir_w[sel];
    assign ov  = ov_w[sel];
    assign bsy = busy_w[sel];
    assign od  = od_w[sel];
    assign bc  = blk_w[sel];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: run every block through ROUNDS steps of the ring generator as plain word math.
    function automatic logic [63:0] model(input logic [63:0] blocks[$], input bit mode,
                                          input int rounds, input logic [63:0] tap,
                                          input logic [63:0] key);
        logic [63:0] lo, u, inj;
        bit fb, i0, i1, i2, i3;
        lo = mode ? key : 64'd0;
        foreach (blocks[b]) begin
            u = blocks[b];
            for (int r = 0; r < rounds; r++) begin
                fb  = lo[0];
                i0  = u[0];
                i1  = u[4] & u[5];
                i2  = (u[9] & u[10]) | (u[13] & u[14]);
                i3  = u[16] | (u[19] & u[21]);
                inj = (64'(fb ^ i0) << 63) | (64'(i1) << 55) | (64'(i2) << 47) | (64'(i3) << 39);
                lo  = (lo >> 1) ^ (fb ? (tap & 64'h7FFF_FFFF_FFFF_FFFF) : 64'd0) ^ inj;
                u   = (u << 1) | (u >> 63);
            end
        end
        return lo;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_block(input logic [63:0] d, input bit last, input bit mode);
        int n = 0;
        din = d; dlast = last; nm = mode; dvld = 1'b1;
        while (!ir && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {63'd0, ir}, 64'd1);
        @(negedge clk);
        dvld = 1'b0;
        din  = {$urandom, $urandom};
        dlast = $urandom_range(0, 1);
    endtask

    task automatic take_digest(input string tag, input logic [63:0] exp, input int exp_lat,
                               input int hold, input int nblk);
        int n = 0;
        logic [63:0] first;
        while (!ov && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_data"}, od, exp);
        first = od;
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            chk({tag, "_hold_data"}, od, first);
            chk({tag, "_hold_vld"}, {63'd0, ov}, 64'd1);
            chk({tag, "_hold_rdy"}, {63'd0, ir}, 64'd0);
            chk({tag, "_hold_busy"}, {63'd0, bsy}, 64'd1);
        end
`ifdef HASH_BLOCK_CNT_EN
        chk({tag, "_blk_cnt"}, 64'(bc), 64'(nblk));
`else
        if (nblk < 0) chk({tag, "_nblk"}, 64'(nblk), 64'd0);
`endif
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        chk({tag, "_vld_clr"}, {63'd0, ov}, 64'd0);
        chk({tag, "_rdy_after"}, {63'd0, ir}, 64'd1);
        chk({tag, "_busy_after"}, {63'd0, bsy}, 64'd0);
        chk({tag, "_data_kept"}, od, first);
`ifdef HASH_BLOCK_CNT_EN
        chk({tag, "_blk_cnt_clr"}, 64'(bc), 64'd0);
`endif
    endtask

    task automatic run_msg(input int nblk);
        logic [63:0] q[$];
        logic [63:0] d;
        bit m, m0;
        m0 = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            if (b == 0) m0 = m;
            q.push_back(d);
            send_block(d, b == nblk - 1, m);
        end
        take_digest("rand", model(q, m0, int'(RNDS[sel]), TAPS[sel], KEYS[sel]),
                    int'(RNDS[sel]), $urandom_range(0, 3), nblk);
    endtask

    initial begin
        reset = 1'b1; nm = 1'b0; din = '0; dvld = 1'b0; dlast = 1'b0; ordy = 1'b0; sel = 2'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_in_ready", {63'd0, ir}, 64'd1);
            chk("rst_out_valid", {63'd0, ov}, 64'd0);
            chk("rst_out_data", od, 64'd0);
            chk("rst_busy", {63'd0, bsy}, 64'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // KEY survives 64 pure rotations of lower
        sel = 2'd0;
        send_block(64'd0, 1'b1, 1'b1);
        take_digest("key64", 64'h5, 64, 0, 1);

        sel = 2'd1;
        send_block(64'h1, 1'b1, 1'b0);
        take_digest("i0_single", 64'h8000_0000_0000_0000, 1, 0, 1);
        send_block(64'h30, 1'b1, 1'b0);
        take_digest("i1_single", 64'h0080_0000_0000_0000, 1, 0, 1);

        // Two-block chain with backpressure on the digest
        send_block(64'h1, 1'b0, 1'b0);
        chk("chain_busy_mid", {63'd0, bsy}, 64'd1);
        send_block(64'h0, 1'b1, 1'b1);
        take_digest("chain2", 64'h4000_0000_0000_0000, 1, 10, 2);

        send_block(64'h1, 1'b0, 1'b0);
        send_block(64'h0, 1'b0, 1'b1);
        send_block(64'h0, 1'b1, 1'b1);
        take_digest("chain3", 64'h2000_0000_0000_0000, 1, 2, 3);

        // Reset in the middle of a non-last block discards the chain
        sel = 2'd0;
        send_block(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {63'd0, bsy}, 64'd0);
        chk("midrst_rdy", {63'd0, ir}, 64'd1);
        chk("midrst_vld", {63'd0, ov}, 64'd0);
        send_block(64'd0, 1'b1, 1'b1);
        take_digest("post_rst", 64'h5, 64, 0, 1);

        for (int i = 0; i < 4; i++) run_msg($urandom_range(1, 2));
        sel = 2'd1;
        for (int i = 0; i < 10; i++) run_msg($urandom_range(1, 4));
        sel = 2'd2;
        for (int i = 0; i < 25; i++) run_msg($urandom_range(1, 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
